// File: rtl/mmio_uart_tx.sv
// Store-path UART transmitter: TXDATA/STATUS word registers, byte FIFO, 8N1 serialiser.
// A byte stored at edge N drives the start bit after edge N+1; stores to a full FIFO are dropped and set overflow.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        tx,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic [1:0]    state;
  logic [BW-1:0] baud;
  logic [2:0]    idx;
  logic [7:0]    shift;

  logic full, empty, frame_active, bit_end;
  logic wr_data, wr_stat, push, pop;
  logic [3:0] cnt4;

  assign sel          = (a[31:3] == BASE_ADDR[31:3]);
  assign wr_data      = we & sel & ~a[2];
  assign wr_stat      = we & sel & a[2];
  assign full         = (count == CW'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign frame_active = (state != IDLE);
  assign busy         = frame_active | ~empty;
  assign bit_end      = (baud == BW'(CLKS_PER_BIT - 1));
  assign push         = wr_data & ~full;
  // The serialiser consumes the head from IDLE, or at the end of a stop bit to chain frames.
  assign pop          = ~empty & ((state == IDLE) | ((state == STOP) & bit_end));
  assign cnt4         = 4'(count);

  always_comb begin
    rd = 32'h0;
    if (sel && a[2])
      rd = {24'h0, cnt4, overflow, frame_active, empty, full};
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= wd[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Full is judged before the edge, so a same-edge pop does not rescue the byte.
      if (wr_data && full)
        overflow <= 1'b1;
      else if (wr_stat && wd[3])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tx    <= 1'b1;
      shift <= 8'h0;
      baud  <= '0;
      idx   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          baud <= '0;
          if (!empty) begin
            shift <= mem[rptr];
            tx    <= 1'b0;
            state <= START;
          end else begin
            tx <= 1'b1;
          end
        end
        START: begin
          baud <= bit_end ? '0 : baud + BW'(1);
          if (bit_end) begin
            tx    <= shift[0];
            idx   <= 3'd0;
            state <= DATA;
          end
        end
        DATA: begin
          baud <= bit_end ? '0 : baud + BW'(1);
          if (bit_end) begin
            shift <= {1'b0, shift[7:1]};
            if (idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
              tx  <= shift[1];
            end
          end
        end
        STOP: begin
          baud <= bit_end ? '0 : baud + BW'(1);
          if (bit_end) begin
            if (!empty) begin
              shift <= mem[rptr];
              tx    <= 1'b0;
              state <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=16, FIFO_DEPTH=4, BASE 0x100.
module tb_mmio_uart_tx;

  logic        clk;
  logic        reset;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        sel;
  logic        tx;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mmio_uart_tx #(
    .BASE_ADDR(32'h0000_0100),
    .CLKS_PER_BIT(16),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .we(we),
    .a(a),
    .wd(wd),
    .rd(rd),
    .sel(sel),
    .tx(tx),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench 1ns after the n-th following rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    we = 1'b1; a = addr; wd = data;
    step(1);
    we = 1'b0; a = 32'h0; wd = 32'h0;
  endtask

  task automatic read_status(input string name, input logic [31:0] exp);
    a = 32'h104;
    #1;
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL %s: rd=%h expected %h", name, rd, exp);
    end
    a = 32'h0;
  endtask

  task automatic test_reset;
    reset = 1'b1; we = 1'b0; a = 32'h0; wd = 32'h0;
    step(3);
    reset = 1'b0;
    step(50);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: tx=%b expected 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b expected 0", busy); end
    read_status("reset_status", 32'h0000_0002);
  endtask

  task automatic test_single_frame;
    logic [9:0] exp_bits;
    exp_bits = {1'b1, 8'h55, 1'b0};
    store(32'h100, 32'h55);
    read_status("queued_status", 32'h0000_0010);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL pre_start_tx: tx=%b expected 1", tx); end
    step(1);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL start_edge_tx: tx=%b expected 0", tx); end
    read_status("active_status", 32'h0000_0006);
    step(8);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (tx !== exp_bits[i]) begin
        errors++;
        $display("FAIL frame55_bit%0d: tx=%b expected %b", i, tx, exp_bits[i]);
      end
      if (i < 9) step(16);
    end
    step(7);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_last_cycle: busy=%b expected 1", busy); end
    step(1);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL busy_drop: busy=%b tx=%b expected busy 0 tx 1", busy, tx);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3];
    logic [9:0] frame;
    bytes[0] = 8'hA1; bytes[1] = 8'h3C; bytes[2] = 8'hFF;
    store(32'h100, 32'h0000_00A1);
    store(32'h100, 32'h0000_003C);
    store(32'h100, 32'h0000_00FF);
    step(7);
    for (int k = 0; k < 3; k++) begin
      frame = {1'b1, bytes[k], 1'b0};
      for (int j = 0; j < 10; j++) begin
        checks++;
        if (tx !== frame[j]) begin
          errors++;
          $display("FAIL b2b_frame%0d_bit%0d: tx=%b expected %b", k, j, tx, frame[j]);
        end
        if (!(k == 2 && j == 9)) step(16);
      end
    end
    step(8);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done: busy=%b expected 0", busy); end
  endtask

  task automatic test_overflow;
    int waited;
    store(32'h100, 32'h11);
    step(2);
    for (int i = 0; i < 5; i++) store(32'h100, 32'h21 + i);
    // count 4, overflow, frame active, full
    read_status("overflow_status", 32'h0000_004D);
    store(32'h104, 32'h0000_0008);
    read_status("overflow_cleared", 32'h0000_0045);
    waited = 0;
    while (busy === 1'b1 && waited < 1200) begin
      step(1);
      waited++;
    end
    checks++;
    // 1 frame in flight plus 4 queued, nothing more
    if (busy !== 1'b0 || waited < 700) begin
      errors++;
      $display("FAIL overflow_drain: busy=%b after %0d cycles, expected idle after 700..1200", busy, waited);
    end
    read_status("overflow_idle", 32'h0000_0002);
  endtask

  task automatic test_reset_mid;
    logic saw_low;
    store(32'h100, 32'h5A);
    store(32'h100, 32'h66);
    store(32'h100, 32'h77);
    step(40);
    read_status("mid_status", 32'h0000_0024);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: tx=%b busy=%b expected tx 1 busy 0", tx, busy);
    end
    read_status("reset_mid_status", 32'h0000_0002);
    saw_low = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    checks++;
    if (saw_low !== 1'b0) begin errors++; $display("FAIL reset_no_frames: tx went low=%b expected 0", saw_low); end
  endtask

  task automatic test_decode;
    we = 1'b1; a = 32'h60; wd = 32'h99;
    #1;
    checks++;
    if (sel !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL dmem_decode: sel=%b rd=%h expected sel 0 rd 0", sel, rd);
    end
    step(1);
    we = 1'b0;
    read_status("dmem_untouched", 32'h0000_0002);
    a = 32'h100;
    #1;
    checks++;
    if (sel !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL txdata_read: sel=%b rd=%h expected sel 1 rd 0", sel, rd);
    end
    a = 32'h107;
    #1;
    checks++;
    if (rd !== 32'h0000_0002) begin errors++; $display("FAIL status_alias: rd=%h expected 00000002", rd); end
    a = 32'h108;
    #1;
    checks++;
    if (sel !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL above_window: sel=%b rd=%h expected sel 0 rd 0", sel, rd);
    end
    a = 32'h0;
    step(20);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL decode_idle: tx=%b busy=%b expected tx 1 busy 0", tx, busy);
    end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_overflow;
    test_reset_mid;
    test_decode;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
